// File: rtl/pwm_multichannel_pkg.sv
// Shared definitions for the multichannel PWM: register map, CTRL bit
// positions, and the alignment-mode and count-direction encodings.
package pwm_multichannel_pkg;

  localparam logic [4:0] ADDR_CTRL      = 5'd0;
  localparam logic [4:0] ADDR_PERIOD    = 5'd1;
  localparam logic [4:0] ADDR_PRESC     = 5'd2;
  localparam logic [4:0] ADDR_DUTY_BASE = 5'd8;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_MODE_BIT   = 1;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Register-write port from the MicroBlaze MCS IO bus into the PWM block.
interface pwm_multichannel_if;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/pwm_multichannel_timebase.sv
// Prescaler plus edge (sawtooth) or center (triangle) counter; flags the tick
// on which a PWM period ends so the owner can reload its active registers.
module pwm_multichannel_timebase
  import pwm_multichannel_pkg::*;
#(
  parameter int CNT_W   = 12,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  pwm_mode_e          mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   cnt,
  output logic               boundary
);

  logic [PRESC_W-1:0] presc_cnt_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  cnt_dir_e           dir_r;
  cnt_dir_e           dir_nxt_s;
  logic               tick_s;
  logic               wrap_s;

  // next counter value and period-end detection for the current alignment mode
  always_comb begin
    tick_s    = (presc_cnt_r >= presc);
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_r;
    wrap_s    = 1'b0;
    if (period == '0) begin
      cnt_nxt_s = '0;
      dir_nxt_s = DIR_UP;
      wrap_s    = 1'b1;
    end else begin
      case (mode)
        MODE_EDGE: begin
          dir_nxt_s = DIR_UP;
          if (cnt_r >= period) begin
            cnt_nxt_s = '0;
            wrap_s    = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        MODE_CENTER: begin
          if (dir_r == DIR_UP) begin
            if (cnt_r >= period) begin
              cnt_nxt_s = cnt_r - CNT_W'(1);
              dir_nxt_s = DIR_DOWN;
            end else begin
              cnt_nxt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            // reaching zero on the way down closes the period
            if (cnt_r <= CNT_W'(1)) begin
              cnt_nxt_s = '0;
              dir_nxt_s = DIR_UP;
              wrap_s    = 1'b1;
            end else begin
              cnt_nxt_s = cnt_r - CNT_W'(1);
            end
          end
        end
        default: begin
          cnt_nxt_s = '0;
          dir_nxt_s = DIR_UP;
          wrap_s    = 1'b1;
        end
      endcase
    end
  end

  // prescaler and counter state, held cleared while stopped
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_cnt_r <= '0;
      cnt_r       <= '0;
      dir_r       <= DIR_UP;
    end else if (!run) begin
      presc_cnt_r <= '0;
      cnt_r       <= '0;
      dir_r       <= DIR_UP;
    end else if (tick_s) begin
      presc_cnt_r <= '0;
      cnt_r       <= cnt_nxt_s;
      dir_r       <= dir_nxt_s;
    end else begin
      presc_cnt_r <= presc_cnt_r + PRESC_W'(1);
    end
  end

  assign cnt      = cnt_r;
  assign boundary = run && tick_s && wrap_s;

endmodule

// File: rtl/pwm_multichannel.sv
// NUM_CH-channel PWM with programmable period/prescaler, edge or center
// alignment, and shadowed configuration reloaded at period boundaries.
module pwm_multichannel
  import pwm_multichannel_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 12,
  parameter int PRESC_W  = 16,
  parameter bit POLARITY = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  pwm_multichannel_if.slave   bus,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_tick,
  output logic                running
);

  logic               enable_r;
  pwm_mode_e          mode_sh_r;
  logic [CNT_W-1:0]   period_sh_r;
  logic [PRESC_W-1:0] presc_sh_r;
  logic [CNT_W-1:0]   duty_sh_r [NUM_CH];

  pwm_mode_e          mode_act_r;
  logic [CNT_W-1:0]   period_act_r;
  logic [PRESC_W-1:0] presc_act_r;
  logic [CNT_W-1:0]   duty_act_r [NUM_CH];

  logic [NUM_CH-1:0]  pwm_out_r;
  logic               period_tick_r;

  logic               wr_ctrl_s;
  logic               wr_period_s;
  logic               wr_presc_s;
  logic [NUM_CH-1:0]  wr_duty_s;
  logic [NUM_CH-1:0]  active_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               boundary_s;
  logic               unused_s;

  // upper write-data bits are don't-care for every register
  assign unused_s = ^bus.wr_data;

  // decode of the scalar registers
  always_comb begin
    wr_ctrl_s   = 1'b0;
    wr_period_s = 1'b0;
    wr_presc_s  = 1'b0;
    if (bus.wr_en) begin
      wr_ctrl_s   = (bus.wr_addr == ADDR_CTRL);
      wr_period_s = (bus.wr_addr == ADDR_PERIOD);
      wr_presc_s  = (bus.wr_addr == ADDR_PRESC);
    end else begin
      wr_ctrl_s   = 1'b0;
      wr_period_s = 1'b0;
      wr_presc_s  = 1'b0;
    end
  end

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      assign wr_duty_s[ch] = bus.wr_en && (bus.wr_addr == (ADDR_DUTY_BASE + 5'(ch)));
      assign active_s[ch]  = enable_r && (duty_act_r[ch] > cnt_s);
    end
  endgenerate

  // write port into the shadow registers; enable takes effect at once
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable_r    <= 1'b0;
      mode_sh_r   <= MODE_EDGE;
      period_sh_r <= '0;
      presc_sh_r  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_r[i] <= '0;
      end
    end else begin
      if (wr_ctrl_s) begin
        enable_r  <= bus.wr_data[CTRL_ENABLE_BIT];
        mode_sh_r <= pwm_mode_e'(bus.wr_data[CTRL_MODE_BIT]);
      end
      if (wr_period_s) begin
        period_sh_r <= bus.wr_data[CNT_W-1:0];
      end
      if (wr_presc_s) begin
        presc_sh_r <= bus.wr_data[PRESC_W-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty_s[i]) begin
          duty_sh_r[i] <= bus.wr_data[CNT_W-1:0];
        end
      end
    end
  end

  // active copies follow the shadows while stopped and reload on each boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_act_r   <= MODE_EDGE;
      period_act_r <= '0;
      presc_act_r  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act_r[i] <= '0;
      end
    end else if (!enable_r || boundary_s) begin
      mode_act_r   <= mode_sh_r;
      period_act_r <= period_sh_r;
      presc_act_r  <= presc_sh_r;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act_r[i] <= duty_sh_r[i];
      end
    end
  end

  pwm_multichannel_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk      (clk),
    .reset    (reset),
    .run      (enable_r),
    .mode     (mode_act_r),
    .period   (period_act_r),
    .presc    (presc_act_r),
    .cnt      (cnt_s),
    .boundary (boundary_s)
  );

  // output stage: compare result and boundary flag, one clock after the counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_out_r     <= {NUM_CH{~POLARITY}};
      period_tick_r <= 1'b0;
    end else begin
      pwm_out_r     <= active_s ^ {NUM_CH{~POLARITY}};
      period_tick_r <= boundary_s;
    end
  end

  assign pwm_out     = pwm_out_r;
  assign period_tick = period_tick_r;
  assign running     = enable_r;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel (4 channels, CNT_W 12, active-high outputs).
module tb_pwm_multichannel;
  import pwm_multichannel_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pwm_out;
  logic       period_tick;
  logic       running;
  int         total = 0;
  int         bad = 0;
  int         highs;
  int         ticks;

  pwm_multichannel_if bus ();

  pwm_multichannel #(
    .NUM_CH   (4),
    .CNT_W    (12),
    .PRESC_W  (16),
    .POLARITY (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'd0;
  endtask

  initial begin
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'd0;
    step();
    step();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_run", 32'(running), 32'd0);
    reset = 1'b1;
    step();

    // edge mode, PERIOD 9, duty 3 and 10
    wr(ADDR_PERIOD, 32'd9);
    wr(5'd8, 32'd3);
    wr(5'd9, 32'd10);
    wr(ADDR_CTRL, 32'h1);
    chk("t1_run", 32'(running), 32'd1);
    chk("t1_pwm_e0", 32'(pwm_out), 32'd0);
    highs = 0;
    ticks = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("t1_pwm0", 32'(pwm_out[0]), 32'(((k - 1) % 10) < 3));
      chk("t1_pwm1", 32'(pwm_out[1]), 32'd1);
      chk("t1_pwm32", 32'(pwm_out[3:2]), 32'd0);
      chk("t1_tick", 32'(period_tick), 32'((k % 10) == 0));
      highs += int'(pwm_out[0]);
      ticks += int'(period_tick);
    end
    chk("t1_highs", 32'(highs), 32'd9);
    chk("t1_ticks", 32'(ticks), 32'd3);

    // shadow: duty write mid-period, then a write on the boundary clock
    for (int k = 31; k <= 35; k++) step();
    wr(5'd8, 32'd7);
    chk("t3_pwm0_wr", 32'(pwm_out[0]), 32'd0);
    for (int k = 37; k <= 60; k++) begin
      step();
      chk("t3_pwm0", 32'(pwm_out[0]), 32'(((k - 1) % 10) < ((k >= 41) ? 7 : 3)));
      chk("t3_tick", 32'(period_tick), 32'((k % 10) == 0));
    end
    for (int k = 61; k <= 69; k++) step();
    wr(5'd8, 32'd2);
    chk("t3b_pwm0_wr", 32'(pwm_out[0]), 32'd0);
    chk("t3b_tick_wr", 32'(period_tick), 32'd1);
    for (int k = 71; k <= 90; k++) begin
      step();
      chk("t3b_pwm0", 32'(pwm_out[0]), 32'(((k - 1) % 10) < ((k >= 81) ? 2 : 7)));
    end

    // bounds: duty 0 stays low, duty above PERIOD stays high
    wr(ADDR_CTRL, 32'h0);
    chk("t4_run_off", 32'(running), 32'd0);
    step();
    chk("t4_pwm_off", 32'(pwm_out), 32'd0);
    chk("t4_tick_off", 32'(period_tick), 32'd0);
    wr(5'd8, 32'd0);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t4_duty0", 32'(pwm_out[1:0]), 32'd2);
    end
    // PERIOD 0: constant active, every tick a boundary
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_PERIOD, 32'd0);
    wr(5'd8, 32'd1);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t4_p0_pwm", 32'(pwm_out), 32'h3);
      chk("t4_p0_tick", 32'(period_tick), 32'd1);
    end
    // writes outside the map are dropped
    wr(5'd12, 32'd0);
    wr(5'd13, 32'd0);
    wr(5'd4, 32'd0);
    wr(5'd16, 32'd0);
    wr(5'd24, 32'd0);
    step();
    step();
    chk("t4_unmap_pwm", 32'(pwm_out), 32'h3);
    chk("t4_unmap_run", 32'(running), 32'd1);
    chk("t4_unmap_tick", 32'(period_tick), 32'd1);

    // center mode, PERIOD 4, duty 2: counter 0,1,2,3,4,3,2,1
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_PERIOD, 32'd4);
    wr(5'd8, 32'd2);
    wr(ADDR_CTRL, 32'h2);
    wr(ADDR_CTRL, 32'h3);
    highs = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("t2_pwm0", 32'(pwm_out[0]), 32'((((k - 1) % 8) <= 1) || (((k - 1) % 8) == 7)));
      chk("t2_pwm1", 32'(pwm_out[1]), 32'd1);
      chk("t2_tick", 32'(period_tick), 32'((k % 8) == 0));
      highs += int'(pwm_out[0]);
    end
    chk("t2_highs", 32'(highs), 32'd9);

    // prescaler 2: counter advances every third clock
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_PERIOD, 32'd9);
    wr(ADDR_PRESC, 32'd2);
    wr(5'd8, 32'd5);
    wr(ADDR_CTRL, 32'h1);
    highs = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      chk("t5_pwm0", 32'(pwm_out[0]), 32'((((k - 1) / 3) % 10) < 5));
      chk("t5_tick", 32'(period_tick), 32'((k % 30) == 0));
      if (k <= 30) highs += int'(pwm_out[0]);
    end
    chk("t5_highs", 32'(highs), 32'd15);

    // disable at cnt 4, re-enable restarts from 0, then reset mid-period
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_PRESC, 32'd0);
    wr(5'd8, 32'd7);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 4; k++) step();
    chk("t6_pwm_pre", 32'(pwm_out[0]), 32'd1);
    wr(ADDR_CTRL, 32'h0);
    chk("t6_run_off", 32'(running), 32'd0);
    chk("t6_pwm_last", 32'(pwm_out[0]), 32'd1);
    step();
    chk("t6_pwm_off", 32'(pwm_out), 32'd0);
    chk("t6_tick_off", 32'(period_tick), 32'd0);
    step();
    step();
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t6_re_pwm0", 32'(pwm_out[0]), 32'(((k - 1) % 10) < 7));
      chk("t6_re_tick", 32'(period_tick), 32'(k == 10));
    end
    step();
    step();
    reset       = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_CTRL;
    bus.wr_data = 32'h1;
    step();
    chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t6_rst_run", 32'(running), 32'd0);
    chk("t6_rst_tick", 32'(period_tick), 32'd0);
    step();
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    step();
    chk("t6_post_run", 32'(running), 32'd0);
    wr(ADDR_CTRL, 32'h1);
    step();
    chk("t6_post_pwm", 32'(pwm_out), 32'd0);
    chk("t6_post_tick", 32'(period_tick), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
